// File: rtl/sobel_stream_if.sv
// sobel_stream_if: streaming port bundle for sobel_stream.
//   in_*       : one 3x3 neighbourhood beat per handshake (valid/ready)
//   mode       : 0 = binary edge map, 1 = saturated magnitude (per beat)
//   threshold  : binary-mode threshold (per beat)
//   out_*      : one filtered pixel per handshake (valid/ready)
// master drives the input beats and accepts the output; slave is the filter.
interface sobel_stream_if #(
    parameter int PIX_W = 8,
    parameter int ROW_W = 9,
    parameter int COL_W = 10
);
    logic                 in_valid;
    logic                 in_ready;
    logic [ROW_W-1:0]     in_row;
    logic [COL_W-1:0]     in_col;
    logic [8*PIX_W-1:0]   in_pixels;
    logic                 mode;
    logic [PIX_W+2:0]     threshold;
    logic                 out_valid;
    logic                 out_ready;
    logic [PIX_W-1:0]     out_pixel;
    logic [ROW_W-1:0]     out_row;
    logic [COL_W-1:0]     out_col;

    modport master (
        output in_valid, in_row, in_col, in_pixels, mode, threshold, out_ready,
        input  in_ready, out_valid, out_pixel, out_row, out_col
    );

    modport slave (
        input  in_valid, in_row, in_col, in_pixels, mode, threshold, out_ready,
        output in_ready, out_valid, out_pixel, out_row, out_col
    );
endinterface

// File: rtl/sobel_stream.sv
// sobel_stream: fully pipelined 3x3 Sobel filter, one neighbourhood per cycle.
//   clk    : system clock, rising edge
//   reset  : asynchronous active-high reset
//   bus    : sobel_stream_if.slave
//            in_pixels packed {tl, t, tr, ml, mr, bl, b, br}, tl in the MSB slice
//            out_pixel is a binary edge map (mode 0) or saturated |gx|+|gy| (mode 1);
//            border pixels (first/last row or column) always produce 0.
// Four register stages (sums, abs differences, magnitude, output). The whole
// pipeline advances together whenever the output register is empty or being
// consumed, so in_ready depends only on out_valid/out_ready.
module sobel_stream #(
    parameter int PIX_W   = 8,
    parameter int MAX_ROW = 480,
    parameter int MAX_COL = 640,
    parameter int ROW_W   = 9,
    parameter int COL_W   = 10
) (
    input  logic          clk,
    input  logic          reset,
    sobel_stream_if.slave bus
);
    localparam int SW = PIX_W + 2;   // width of one weighted column/row sum
    localparam int MW = PIX_W + 3;   // width of the exact magnitude
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MAX_ROW - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(MAX_COL - 1);

    logic en;

    // Neighbourhood taps
    logic [PIX_W-1:0] p_tl, p_t, p_tr, p_ml, p_mr, p_bl, p_b, p_br;

    assign p_tl = bus.in_pixels[7*PIX_W +: PIX_W];
    assign p_t  = bus.in_pixels[6*PIX_W +: PIX_W];
    assign p_tr = bus.in_pixels[5*PIX_W +: PIX_W];
    assign p_ml = bus.in_pixels[4*PIX_W +: PIX_W];
    assign p_mr = bus.in_pixels[3*PIX_W +: PIX_W];
    assign p_bl = bus.in_pixels[2*PIX_W +: PIX_W];
    assign p_b  = bus.in_pixels[1*PIX_W +: PIX_W];
    assign p_br = bus.in_pixels[0*PIX_W +: PIX_W];

    // Stage 0 (combinational): weighted sums and border detection
    logic [SW-1:0] gx_r_c, gx_l_c, gy_b_c, gy_t_c;
    logic          edge_c;

    always_comb begin
        gx_r_c = {2'b00, p_tr} + {1'b0, p_mr, 1'b0} + {2'b00, p_br};
        gx_l_c = {2'b00, p_tl} + {1'b0, p_ml, 1'b0} + {2'b00, p_bl};
        gy_b_c = {2'b00, p_bl} + {1'b0, p_b,  1'b0} + {2'b00, p_br};
        gy_t_c = {2'b00, p_tl} + {1'b0, p_t,  1'b0} + {2'b00, p_tr};
        edge_c = (bus.in_row == '0) || (bus.in_row == LAST_ROW) ||
                 (bus.in_col == '0) || (bus.in_col == LAST_COL);
    end

    // Stage 1 registers
    logic             s1_valid;
    logic [SW-1:0]    s1_gx_r, s1_gx_l, s1_gy_b, s1_gy_t;
    logic [ROW_W-1:0] s1_row;
    logic [COL_W-1:0] s1_col;
    logic             s1_mode;
    logic [MW-1:0]    s1_thr;
    logic             s1_edge;

    // Stage 2 registers
    logic             s2_valid;
    logic [SW-1:0]    s2_ax, s2_ay;
    logic [ROW_W-1:0] s2_row;
    logic [COL_W-1:0] s2_col;
    logic             s2_mode;
    logic [MW-1:0]    s2_thr;
    logic             s2_edge;

    // Stage 3 registers
    logic             s3_valid;
    logic [MW-1:0]    s3_mag;
    logic [ROW_W-1:0] s3_row;
    logic [COL_W-1:0] s3_col;
    logic             s3_mode;
    logic [MW-1:0]    s3_thr;
    logic             s3_edge;

    // Stage 4 (output) registers
    logic             out_valid_q;
    logic [PIX_W-1:0] out_pixel_q;
    logic [ROW_W-1:0] out_row_q;
    logic [COL_W-1:0] out_col_q;

    // Single global enable: every stage moves together, so a stall of k
    // cycles delays every in-flight beat by exactly k cycles and bubbles
    // simply travel as cleared valid bits.
    assign en           = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_gx_r  <= '0;
            s1_gx_l  <= '0;
            s1_gy_b  <= '0;
            s1_gy_t  <= '0;
            s1_row   <= '0;
            s1_col   <= '0;
            s1_mode  <= 1'b0;
            s1_thr   <= '0;
            s1_edge  <= 1'b0;
        end else if (en) begin
            s1_valid <= bus.in_valid;
            s1_gx_r  <= gx_r_c;
            s1_gx_l  <= gx_l_c;
            s1_gy_b  <= gy_b_c;
            s1_gy_t  <= gy_t_c;
            s1_row   <= bus.in_row;
            s1_col   <= bus.in_col;
            s1_mode  <= bus.mode;
            s1_thr   <= bus.threshold;
            s1_edge  <= edge_c;
        end
    end

    // Absolute differences of the opposing sums
    logic [SW-1:0] ax_c, ay_c;

    always_comb begin
        ax_c = (s1_gx_r >= s1_gx_l) ? (s1_gx_r - s1_gx_l) : (s1_gx_l - s1_gx_r);
        ay_c = (s1_gy_b >= s1_gy_t) ? (s1_gy_b - s1_gy_t) : (s1_gy_t - s1_gy_b);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_ax    <= '0;
            s2_ay    <= '0;
            s2_row   <= '0;
            s2_col   <= '0;
            s2_mode  <= 1'b0;
            s2_thr   <= '0;
            s2_edge  <= 1'b0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_ax    <= ax_c;
            s2_ay    <= ay_c;
            s2_row   <= s1_row;
            s2_col   <= s1_col;
            s2_mode  <= s1_mode;
            s2_thr   <= s1_thr;
            s2_edge  <= s1_edge;
        end
    end

    // Exact magnitude, one bit wider than either operand
    logic [MW-1:0] mag_c;

    assign mag_c = {1'b0, s2_ax} + {1'b0, s2_ay};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3_valid <= 1'b0;
            s3_mag   <= '0;
            s3_row   <= '0;
            s3_col   <= '0;
            s3_mode  <= 1'b0;
            s3_thr   <= '0;
            s3_edge  <= 1'b0;
        end else if (en) begin
            s3_valid <= s2_valid;
            s3_mag   <= mag_c;
            s3_row   <= s2_row;
            s3_col   <= s2_col;
            s3_mode  <= s2_mode;
            s3_thr   <= s2_thr;
            s3_edge  <= s2_edge;
        end
    end

    // Output pixel selection: border forces 0, otherwise threshold or saturate
    logic [PIX_W-1:0] pix_c;

    always_comb begin
        if (s3_edge) begin
            pix_c = '0;
        end else if (!s3_mode) begin
            pix_c = (s3_mag >= s3_thr) ? '1 : '0;
        end else if (s3_mag[MW-1:PIX_W] != '0) begin
            pix_c = '1;
        end else begin
            pix_c = s3_mag[PIX_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else if (en) begin
            out_valid_q <= s3_valid;
            out_pixel_q <= pix_c;
            out_row_q   <= s3_row;
            out_col_q   <= s3_col;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_pixel = out_pixel_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_col   = out_col_q;
endmodule

// File: tb/tb_sobel_stream.sv
// tb_sobel_stream: self-checking bench for sobel_stream (8-bit, 480x640).
// Inputs are driven on the falling edge; outputs are observed on the falling
// edge, one half cycle away from the capturing rising edge.
module tb_sobel_stream;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    sobel_stream_if #(.PIX_W(8), .ROW_W(9), .COL_W(10)) sif ();

    sobel_stream #(
        .PIX_W  (8),
        .MAX_ROW(480),
        .MAX_COL(640),
        .ROW_W  (9),
        .COL_W  (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (sif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int px;
        int row;
        int col;
    } exp_t;

    exp_t exp_q[$];

    function automatic logic [63:0] pack8(input int tl, input int t, input int tr,
                                          input int ml, input int mr,
                                          input int bl, input int b, input int br);
        return {8'(tl), 8'(t), 8'(tr), 8'(ml), 8'(mr), 8'(bl), 8'(b), 8'(br)};
    endfunction

    // Reference: full signed Sobel gradients, L1 magnitude, then output rule.
    function automatic int model_pixel(input logic [63:0] pix, input int row, input int col,
                                       input bit md, input int thr);
        int p[8];
        int gx, gy, mag;
        for (int i = 0; i < 8; i++) p[i] = int'((pix >> (8 * (7 - i))) & 64'hFF);
        // p: 0 tl, 1 t, 2 tr, 3 ml, 4 mr, 5 bl, 6 b, 7 br
        gx = (p[2] + 2 * p[4] + p[7]) - (p[0] + 2 * p[3] + p[5]);
        gy = (p[5] + 2 * p[6] + p[7]) - (p[0] + 2 * p[1] + p[2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        mag = gx + gy;
        if (row == 0 || row == 479 || col == 0 || col == 639) return 0;
        if (!md) return (mag >= thr) ? 255 : 0;
        return (mag > 255) ? 255 : mag;
    endfunction

    task automatic drive_beat(input logic [63:0] pix, input int row, input int col,
                              input bit md, input int thr);
        sif.in_valid  = 1'b1;
        sif.in_pixels = pix;
        sif.in_row    = 9'(row);
        sif.in_col    = 10'(col);
        sif.mode      = md;
        sif.threshold = 11'(thr);
    endtask

    // Sends one beat into an empty pipeline and reports the observed
    // latency (edges since acceptance, -1 if nothing emerged) and outputs.
    task automatic send_single(input logic [63:0] pix, input int row, input int col,
                               input bit md, input int thr,
                               output int lat, output int px, output int r, output int c);
        lat = -1; px = -1; r = -1; c = -1;
        @(negedge clk);
        sif.out_ready = 1'b1;
        drive_beat(pix, row, col, md, thr);
        @(negedge clk);
        sif.in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (sif.out_valid === 1'b1) begin
                lat = k;
                px  = int'(sif.out_pixel);
                r   = int'(sif.out_row);
                c   = int'(sif.out_col);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        sif.in_valid = 1'b0; sif.out_ready = 1'b1; sif.in_pixels = '0;
        sif.in_row = '0; sif.in_col = '0; sif.mode = 1'b0; sif.threshold = '0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (sif.out_valid !== 1'b0 || sif.out_pixel !== 8'd0 || sif.out_row !== 9'd0 || sif.out_col !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b pixel=%0d row=%0d col=%0d expected all 0",
                     sif.out_valid, sif.out_pixel, sif.out_row, sif.out_col);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (sif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", sif.in_ready);
        end
    endtask

    task automatic test_gradient();
        // {right-column value (others 0 unless flat), mode, threshold, expected pixel}
        int tab[6][4] = '{'{-1, 0, 128, 0}, '{255, 0, 128, 255}, '{255, 1, 0, 255},
                          '{10, 0, 128, 0}, '{10, 0, 40, 255}, '{10, 1, 0, 40}};
        int lat, px, r, c;
        logic [63:0] pix;
        for (int i = 0; i < 6; i++) begin
            if (tab[i][0] < 0) pix = pack8(100, 100, 100, 100, 100, 100, 100, 100);
            else pix = pack8(0, 0, tab[i][0], 0, tab[i][0], 0, 0, tab[i][0]);
            send_single(pix, 5, 5, tab[i][1] != 0, tab[i][2], lat, px, r, c);
            checks++;
            if (lat !== 4) begin
                errors++;
                $display("FAIL gradient_latency[%0d]: got %0d expected 4", i, lat);
            end
            checks++;
            if (px !== tab[i][3] || r !== 5 || c !== 5) begin
                errors++;
                $display("FAIL gradient_pixel[%0d]: got pixel=%0d row=%0d col=%0d expected pixel=%0d row=5 col=5",
                         i, px, r, c, tab[i][3]);
            end
        end
    endtask

    task automatic test_border();
        int pos[3][2] = '{'{0, 5}, '{5, 639}, '{479, 5}};
        int lat, px, r, c;
        for (int i = 0; i < 3; i++) begin
            for (int m = 0; m < 2; m++) begin
                send_single(pack8(0, 0, 255, 0, 255, 0, 0, 255), pos[i][0], pos[i][1], m != 0, 128,
                            lat, px, r, c);
                checks++;
                if (lat !== 4 || px !== 0 || r !== pos[i][0] || c !== pos[i][1]) begin
                    errors++;
                    $display("FAIL border[%0d] mode %0d: got lat=%0d pixel=%0d row=%0d col=%0d expected lat=4 pixel=0 row=%0d col=%0d",
                             i, m, lat, px, r, c, pos[i][0], pos[i][1]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] pix[20];
        int   rows[20];
        int   idx = 0, got = 0, iter = 0, last_iter = -1;
        bit   stalled_prev = 1'b0;
        int   h_px = 0, h_row = 0, h_col = 0;
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            pix[i]  = {$urandom, $urandom};
            rows[i] = $urandom_range(1, 478);
        end
        @(negedge clk);
        while (got < 20 && iter < 100) begin
            sif.out_ready = !(iter >= 10 && iter <= 12);
            if (idx < 20) drive_beat(pix[idx], rows[idx], idx + 1, idx[0], 300);
            else sif.in_valid = 1'b0;
            #1;
            checks++;
            if (sif.in_ready !== !(sif.out_valid && !sif.out_ready)) begin
                errors++;
                $display("FAIL b2b_in_ready iter %0d: got %b expected %b", iter, sif.in_ready,
                         !(sif.out_valid && !sif.out_ready));
            end
            if (stalled_prev) begin
                checks++;
                if (sif.out_valid !== 1'b1 || int'(sif.out_pixel) !== h_px ||
                    int'(sif.out_row) !== h_row || int'(sif.out_col) !== h_col) begin
                    errors++;
                    $display("FAIL b2b_hold iter %0d: got valid=%b pixel=%0d row=%0d col=%0d expected 1/%0d/%0d/%0d",
                             iter, sif.out_valid, sif.out_pixel, sif.out_row, sif.out_col, h_px, h_row, h_col);
                end
            end
            if (sif.out_valid && sif.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra iter %0d: got beat row=%0d col=%0d expected none", iter, sif.out_row, sif.out_col);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(sif.out_pixel) !== e.px || int'(sif.out_row) !== e.row || int'(sif.out_col) !== e.col) begin
                        errors++;
                        $display("FAIL b2b_beat %0d: got pixel=%0d row=%0d col=%0d expected %0d/%0d/%0d",
                                 got, sif.out_pixel, sif.out_row, sif.out_col, e.px, e.row, e.col);
                    end
                end
                got++;
                last_iter = iter;
            end
            stalled_prev = sif.out_valid && !sif.out_ready;
            h_px = int'(sif.out_pixel); h_row = int'(sif.out_row); h_col = int'(sif.out_col);
            if (sif.in_valid && sif.in_ready) begin
                exp_q.push_back('{model_pixel(pix[idx], rows[idx], idx + 1, idx[0], 300), rows[idx], idx + 1});
                idx++;
            end
            @(negedge clk);
            iter++;
        end
        sif.in_valid = 1'b0;
        sif.out_ready = 1'b1;
        checks++;
        // 20 beats, 4-cycle latency, 3 stall cycles: last beat leaves on iteration 26
        if (got !== 20 || last_iter !== 26) begin
            errors++;
            $display("FAIL b2b_timing: got beats=%0d last_iter=%0d expected 20 and 26", got, last_iter);
        end
    endtask

    task automatic test_reset_midstream();
        int lat, px, r, c, emitted = 0;
        @(negedge clk);
        sif.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_beat(pack8(0, 0, 200, 0, 200, 0, 0, 200), 7, 20 + i, 1'b1, 0);
            @(negedge clk);
        end
        sif.in_valid = 1'b0;
        checks++;
        if (sif.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: got out_valid=%b expected 1", sif.out_valid);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (sif.out_valid !== 1'b0 || sif.out_pixel !== 8'd0) begin
            errors++;
            $display("FAIL midreset_async: got valid=%b pixel=%0d expected 0/0", sif.out_valid, sif.out_pixel);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (sif.out_valid === 1'b1) emitted++;
        end
        checks++;
        if (emitted !== 0) begin
            errors++;
            $display("FAIL midreset_flush: got %0d emitted beats expected 0", emitted);
        end
        send_single(pack8(0, 0, 10, 0, 10, 0, 0, 10), 9, 33, 1'b1, 0, lat, px, r, c);
        checks++;
        if (lat !== 4 || px !== 40 || r !== 9 || c !== 33) begin
            errors++;
            $display("FAIL midreset_after: got lat=%0d pixel=%0d row=%0d col=%0d expected 4/40/9/33", lat, px, r, c);
        end
    endtask

    task automatic test_random();
        int   n = 300;
        int   idx = 0, got = 0, iter = 0;
        logic [63:0] cp;
        int   cr, cc, ct;
        bit   cm;
        exp_t e;
        exp_q.delete();
        @(negedge clk);
        while (got < n && iter < 4000) begin
            if (idx < n && (iter == 0 || !sif.in_valid || sif.in_ready)) begin
                // new beat: mix wide and small amplitude neighbourhoods
                if ($urandom_range(0, 1) == 0) cp = {$urandom, $urandom};
                else for (int i = 0; i < 8; i++) cp[8*i +: 8] = 8'($urandom_range(0, 40));
                cr = ($urandom_range(0, 7) == 0) ? ($urandom_range(0, 1) ? 479 : 0) : $urandom_range(1, 478);
                cc = ($urandom_range(0, 7) == 0) ? ($urandom_range(0, 1) ? 639 : 0) : $urandom_range(1, 638);
                cm = 1'($urandom_range(0, 1));
                ct = $urandom_range(0, 1200);
            end
            sif.out_ready = ($urandom_range(0, 3) != 0);
            if (idx < n && $urandom_range(0, 4) != 0) drive_beat(cp, cr, cc, cm, ct);
            else sif.in_valid = 1'b0;
            #1;
            checks++;
            if (sif.in_ready !== (!sif.out_valid || sif.out_ready)) begin
                errors++;
                $display("FAIL rand_in_ready iter %0d: got %b expected %b", iter, sif.in_ready,
                         (!sif.out_valid || sif.out_ready));
            end
            if (sif.out_valid && sif.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra iter %0d: got beat row=%0d col=%0d expected none", iter, sif.out_row, sif.out_col);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(sif.out_pixel) !== e.px || int'(sif.out_row) !== e.row || int'(sif.out_col) !== e.col) begin
                        errors++;
                        $display("FAIL rand_beat %0d: got pixel=%0d row=%0d col=%0d expected %0d/%0d/%0d",
                                 got, sif.out_pixel, sif.out_row, sif.out_col, e.px, e.row, e.col);
                    end
                end
                got++;
            end
            if (sif.in_valid && sif.in_ready) begin
                exp_q.push_back('{model_pixel(cp, cr, cc, cm, ct), cr, cc});
                idx++;
            end
            @(negedge clk);
            iter++;
        end
        sif.in_valid = 1'b0;
        sif.out_ready = 1'b1;
        checks++;
        if (got !== n || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL rand_count: got %0d beats (%0d pending) expected %0d (0 pending)", got, exp_q.size(), n);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_gradient();
        test_border();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
